unary_operand_driver: RTL and testbench

Upstream driver for the mod-12 unary adder stage. It accepts a binary operand pair through a valid/ready handshake. It then converts each operand into a unary pulse train on A/B while holding the adder in read mode. Next it switches the adder to write mode for a fixed drain window, and finally reports completion plus the carry events it collected from the adder's C output.

---
 rtl/unary_operand_driver.sv | 149 ++++++++++++++
 tb/tb_unary_operand_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/unary_operand_driver.sv
// ============================================================================
// Module   : unary_operand_driver
// Purpose  : Converts a binary operand pair into unary A/B pulse trains for the
//            mod-MOD unary adder, drains it in write mode and counts carries.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module unary_operand_driver #(
  parameter int WIDTH        = 4,
  parameter int MOD          = 12,
  parameter int WRITE_CYCLES = MOD - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  input  logic             C_in,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             read_or_write,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] carry_count
);

  localparam int c_WCW = (WRITE_CYCLES < 2) ? 1 : $clog2(WRITE_CYCLES + 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_WRITE = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] c_CARRY_MAX = '1;
  localparam logic [c_WCW-1:0] c_WR_LOAD   = c_WCW'(WRITE_CYCLES);
  localparam logic [c_WCW-1:0] c_WR_LAST   = c_WCW'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_cnt_a;
  logic [WIDTH-1:0] r_cnt_b;
  logic [WIDTH-1:0] w_cnt_a_next;
  logic [WIDTH-1:0] w_cnt_b_next;
  logic [c_WCW-1:0] r_wr_cnt;
  logic             r_rd_prev;
  logic [WIDTH-1:0] r_carry_count;
  logic             w_accept;
  logic             w_enter_write;

  assign w_accept      = in_valid && (r_state == c_ST_IDLE);
  assign w_cnt_a_next  = (r_cnt_a != '0) ? r_cnt_a - 1'b1 : '0;
  assign w_cnt_b_next  = (r_cnt_b != '0) ? r_cnt_b - 1'b1 : '0;
  assign w_enter_write = (w_state_next == c_ST_WRITE) && (r_state != c_ST_WRITE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ((a_val == '0) && (b_val == '0)) ? c_ST_WRITE : c_ST_READ;
        end
      end
      c_ST_READ: begin
        if ((w_cnt_a_next == '0) && (w_cnt_b_next == '0)) begin
          w_state_next = c_ST_WRITE;
        end
      end
      c_ST_WRITE: begin
        if (r_wr_cnt == c_WR_LAST) begin
          w_state_next = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        w_state_next = c_ST_IDLE;
      end
      default: begin
        w_state_next = c_ST_IDLE;
      end
    endcase
  end

  // Operand and write-window counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_cnt_a <= a_val;
        r_cnt_b <= b_val;
      end else if (r_state == c_ST_READ) begin
        r_cnt_a <= w_cnt_a_next;
        r_cnt_b <= w_cnt_b_next;
      end

      if (w_enter_write) begin
        r_wr_cnt <= c_WR_LOAD;
      end else if ((r_state == c_ST_WRITE) && (r_wr_cnt != '0)) begin
        r_wr_cnt <= r_wr_cnt - 1'b1;
      end
    end
  end

  // The adder registers C one cycle after the pulse cycle, so carries are
  // sampled only in the cycle following a read-mode cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_prev     <= 1'b0;
      r_carry_count <= '0;
    end else begin
      r_rd_prev <= (r_state == c_ST_READ);
      if (w_accept) begin
        r_carry_count <= '0;
      end else if (r_rd_prev && C_in && (r_carry_count != c_CARRY_MAX)) begin
        r_carry_count <= r_carry_count + 1'b1;
      end
    end
  end

  // Output decode from registered state only
  always_comb begin
    in_ready      = (r_state == c_ST_IDLE);
    busy          = (r_state != c_ST_IDLE);
    en            = (r_state == c_ST_READ) || (r_state == c_ST_WRITE);
    read_or_write = (r_state == c_ST_WRITE);
    A             = (r_state == c_ST_READ) && (r_cnt_a != '0);
    B             = (r_state == c_ST_READ) && (r_cnt_b != '0);
    done          = (r_state == c_ST_DONE);
    carry_count   = r_carry_count;
  end

endmodule

`default_nettype wire

// File: tb/tb_unary_operand_driver.sv
// Bench for unary_operand_driver with a behavioural mod-12 unary adder
// feeding C_in and a queue-based scoreboard checked on each done pulse.
`timescale 1ns/1ps
`default_nettype none

module tb_unary_operand_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic       C_in;
  logic       A;
  logic       B;
  logic       en;
  logic       read_or_write;
  logic       busy;
  logic       done;
  logic [3:0] carry_count;

  unary_operand_driver #(.WIDTH(4), .MOD(12), .WRITE_CYCLES(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_val        (a_val),
    .b_val        (b_val),
    .C_in         (C_in),
    .A            (A),
    .B            (B),
    .en           (en),
    .read_or_write(read_or_write),
    .busy         (busy),
    .done         (done),
    .carry_count  (carry_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural mod-12 unary adder: pulses accumulate in read mode, C is
  // registered on wrap, residue drains one dout pulse per write cycle.
  logic       s_A = 1'b0, s_B = 1'b0, s_en = 1'b0, s_rw = 1'b0;
  logic [4:0] m_res;
  logic       m_c;
  assign C_in = m_c;

  always @(negedge clk) begin
    s_A  = A;
    s_B  = B;
    s_en = en;
    s_rw = read_or_write;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res <= '0;
      m_c   <= 1'b0;
    end else if (s_en && !s_rw) begin
      if (m_res + s_A + s_B >= 12) begin
        m_res <= m_res + s_A + s_B - 12;
        m_c   <= 1'b1;
      end else begin
        m_res <= m_res + s_A + s_B;
        m_c   <= 1'b0;
      end
    end else begin
      m_c <= 1'b0;
      if (s_en && s_rw && m_res != 0) m_res <= m_res - 1'b1;
    end
  end

  typedef struct {
    int a_p;
    int b_p;
    int w_c;
    int lat;
    int carry;
    int dout;
  } exp_t;

  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: tallies pulses per transaction and scores on done
  int t_acc = 0, na = 0, nb = 0, nw = 0, nd = 0;
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      t_acc = cyc;
      na = 0; nb = 0; nw = 0; nd = 0;
    end else if (!rst && busy) begin
      if (en && !read_or_write) begin
        na += int'(A);
        nb += int'(B);
      end
      if (en && read_or_write) begin
        nw++;
        if (m_res != 0) nd++;
        if (A || B) begin
          n_checks++;
          n_fail++;
          $display("FAIL ab_in_write: got A=%0b B=%0b, expected 0 0", A, B);
        end
      end
      if (done) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got done with empty queue at cycle %0d, expected no done", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("a_pulses",    na,               e.a_p);
          chk("b_pulses",    nb,               e.b_p);
          chk("write_cycles", nw,              e.w_c);
          chk("done_latency", cyc - t_acc,     e.lat);
          chk("carry_count", int'(carry_count), e.carry);
          chk("dout_pulses", nd,               e.dout);
        end
      end
    end
  end

  task automatic push_exp(input int ap, input int bp, input int lat, input int carry, input int dout);
    exp_t e;
    e.a_p = ap; e.b_p = bp; e.w_c = 11; e.lat = lat; e.carry = carry; e.dout = dout;
    q.push_back(e);
  endtask

  task automatic send(input int a, input int b, input int lat, input int carry, input int dout);
    @(posedge clk); #1;
    a_val    = 4'(a);
    b_val    = 4'(b);
    in_valid = 1'b1;
    push_exp(a, b, lat, carry, dout);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: got no done within %0d cycles, expected done", max_cyc);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ctl"}, int'({in_ready, busy, en, read_or_write, A, B, done}), int'(7'b1000000));
    chk({name, "_carry"}, int'(carry_count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a_val    = '0;
    b_val    = '0;
    #1;
    chk_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors: a, b, latency, carries, residue drained
    send(3, 5, 17, 0, 8);    wait_done(40);
    send(7, 6, 19, 1, 1);    wait_done(40);
    send(15, 15, 27, 2, 6);  wait_done(40);
    send(0, 0, 12, 0, 0);    wait_done(40);
    send(12, 0, 24, 1, 0);   wait_done(40);

    // in_valid held across a whole transaction with changing operands
    @(posedge clk); #1;
    a_val = 4'd2; b_val = 4'd1; in_valid = 1'b1;
    push_exp(2, 1, 14, 0, 3);
    @(posedge clk); #1;
    a_val = 4'd9; b_val = 4'd9;
    chk("ready_busy", int'(in_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    a_val = 4'd4; b_val = 4'd4;
    push_exp(4, 4, 16, 0, 8);
    wait_done(40);
    @(posedge clk); #1;
    chk("ready_after_done", int'(in_ready), 1);
    @(posedge clk); #1;
    chk("recaptured_busy", int'(busy), 1);
    in_valid = 1'b0;
    wait_done(40);

    // Reset asserted in the third READ cycle aborts without done
    @(posedge clk); #1;
    a_val = 4'd9; b_val = 4'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("read_before_abort", int'({en, read_or_write, A, B}), int'(4'b1011));
    rst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", int'(done), 0);

    send(2, 2, 14, 0, 4);    wait_done(40);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
